// File: rtl/keypad_digit_display.sv
// Captures keypad codes into a newest/previous digit history with a repeat lockout.
// Both digits are time-multiplexed onto a dual common-anode seven-segment display.
module keypad_digit_display #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int LOCKOUT_CYCLES = 2400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex,
  input  logic       hexen,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);

  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [3:0]      digit_new_reg, digit_new_next;
  logic [3:0]      digit_old_reg, digit_old_next;
  logic            hexen_d_reg;
  logic [RW-1:0]   refresh_cnt_reg;
  logic            sel_reg;
  logic            press;
  logic [3:0]      shown;

  assign press = hexen & ~hexen_d_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      lock_cnt_reg  <= '0;
      digit_new_reg <= 4'd0;
      digit_old_reg <= 4'd0;
      hexen_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_cnt_reg  <= lock_cnt_next;
      digit_new_reg <= digit_new_next;
      digit_old_reg <= digit_old_next;
      hexen_d_reg   <= hexen;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lock_cnt_next  = lock_cnt_reg;
    digit_new_next = digit_new_reg;
    digit_old_next = digit_old_reg;
    case (state_reg)
      IDLE: begin
        if (press) begin
          digit_old_next = digit_new_reg;
          digit_new_next = hex;
          lock_cnt_next  = LW'(LOCKOUT_CYCLES - 1);
          state_next     = LOCK;
        end
      end
      LOCK: begin
        // Lockout only ends once the key has actually been released.
        if (lock_cnt_reg != '0)
          lock_cnt_next = lock_cnt_reg - LW'(1);
        else if (!hexen)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Free-running display refresh, independent of the capture FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt_reg <= '0;
      sel_reg         <= 1'b0;
    end else if (refresh_cnt_reg == RW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt_reg <= '0;
      sel_reg         <= ~sel_reg;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
    end
  end

  assign shown = sel_reg ? digit_old_reg : digit_new_reg;

  always_comb begin
    seg = 7'b1000000;
    case (shown)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
  end

  assign an        = sel_reg ? 2'b01 : 2'b10;
  assign digit_new = digit_new_reg;
  assign digit_old = digit_old_reg;
  assign busy      = (state_reg == LOCK);

endmodule
